// File: rtl/qmult_arb_ctrl.sv
// Round-robin front end for one shared combinational sign-magnitude multiplier.
// Each product is returned with the ID of the requester that issued it.
module qmult_arb_ctrl #(
  parameter int N       = 32,
  parameter int Q       = 15,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  output logic [NUM_REQ-1:0]   o_req_ready,
  input  logic [NUM_REQ*N-1:0] i_req_a,
  input  logic [NUM_REQ*N-1:0] i_req_b,
  output logic [N-1:0]         o_mul_a,
  output logic [N-1:0]         o_mul_b,
  input  logic [N-1:0]         i_mul_result,
  input  logic                 i_mul_ovr,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [ID_W-1:0]      o_rsp_id,
  output logic [N-1:0]         o_rsp_result,
  output logic                 o_rsp_ovr,
  output logic                 o_busy,
  output logic [15:0]          o_ovr_count
);

  localparam int CNT_W = 4;

  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ ||
      MUL_LAT < 1 || MUL_LAT > 15 || Q < 0 || Q >= N) begin : g_bad_params
    $error("qmult_arb_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_reg;
  logic [ID_W-1:0]  rr_ptr_reg;
  logic [ID_W-1:0]  id_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [N-1:0]     mul_a_reg;
  logic [N-1:0]     mul_b_reg;
  logic [N-1:0]     result_reg;
  logic             ovr_reg;
  logic [15:0]      ovr_count_reg;

  logic [N-1:0]     req_a_arr [NUM_REQ];
  logic [N-1:0]     req_b_arr [NUM_REQ];
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W:0]    cand;
  logic             accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_a_arr[gi]   = i_req_a[gi*N +: N];
      assign req_b_arr[gi]   = i_req_b[gi*N +: N];
      assign o_req_ready[gi] = accept && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // Scan offsets from the farthest down to zero so the requester closest to
  // the pointer (in wrap order) is the last writer and wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (i_req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Gated by reset so no requester sees an accept while the block is held.
  assign accept = i_rst_n && (state_reg == IDLE) && grant_found;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      id_reg        <= '0;
      cnt_reg       <= '0;
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
      result_reg    <= '0;
      ovr_reg       <= 1'b0;
      ovr_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            mul_a_reg  <= req_a_arr[grant_idx];
            mul_b_reg  <= req_b_arr[grant_idx];
            id_reg     <= grant_idx;
            rr_ptr_reg <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            cnt_reg    <= CNT_W'(MUL_LAT - 1);
            state_reg  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            result_reg <= i_mul_result;
            ovr_reg    <= i_mul_ovr;
            if (i_mul_ovr && (ovr_count_reg != 16'hFFFF)) begin
              ovr_count_reg <= ovr_count_reg + 1'b1;
            end
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_mul_a      = mul_a_reg;
  assign o_mul_b      = mul_b_reg;
  assign o_rsp_valid  = (state_reg == RESP);
  assign o_busy       = (state_reg != IDLE);
  assign o_rsp_id     = id_reg;
  assign o_rsp_result = result_reg;
  assign o_rsp_ovr    = ovr_reg;
  assign o_ovr_count  = ovr_count_reg;

endmodule

// File: tb/tb_qmult_arb_ctrl.sv
// Scoreboard bench for qmult_arb_ctrl: a MUL_LAT=1 instance driven through a
// queue-based monitor, plus a MUL_LAT=4 instance for mid-operation reset.
`timescale 1ns/1ps
module tb_qmult_arb_ctrl;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // MUL_LAT=1 instance
  logic         rst_n, rsp_ready, rsp_valid, rsp_ovr, busy, mul_ovr;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic [31:0]  mul_a, mul_b, mul_result, rsp_result;
  logic [1:0]   rsp_id;
  logic [15:0]  ovr_count;

  // MUL_LAT=4 instance
  logic         rst4_n, rsp_ready4, rsp_valid4, rsp_ovr4, busy4, mul_ovr4;
  logic [3:0]   req_valid4, req_ready4;
  logic [127:0] req_a4, req_b4;
  logic [31:0]  mul_a4, mul_b4, mul_result4, rsp_result4;
  logic [1:0]   rsp_id4;
  logic [15:0]  ovr_count4;

  qmult_arb_ctrl #(.N(32), .Q(15), .NUM_REQ(4), .ID_W(2), .MUL_LAT(1)) dut (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .o_mul_a(mul_a), .o_mul_b(mul_b),
    .i_mul_result(mul_result), .i_mul_ovr(mul_ovr), .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id), .o_rsp_result(rsp_result),
    .o_rsp_ovr(rsp_ovr), .o_busy(busy), .o_ovr_count(ovr_count));

  qmult_arb_ctrl #(.N(32), .Q(15), .NUM_REQ(4), .ID_W(2), .MUL_LAT(4)) dut4 (
    .i_clk(i_clk), .i_rst_n(rst4_n), .i_req_valid(req_valid4), .o_req_ready(req_ready4),
    .i_req_a(req_a4), .i_req_b(req_b4), .o_mul_a(mul_a4), .o_mul_b(mul_b4),
    .i_mul_result(mul_result4), .i_mul_ovr(mul_ovr4), .o_rsp_valid(rsp_valid4),
    .i_rsp_ready(rsp_ready4), .o_rsp_id(rsp_id4), .o_rsp_result(rsp_result4),
    .o_rsp_ovr(rsp_ovr4), .o_busy(busy4), .o_ovr_count(ovr_count4));

  // Q15 sign-magnitude multiplier; saturates the magnitude on overflow.
  function automatic logic [32:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    logic [61:0] p;
    logic [46:0] m;
    p = {31'b0, a[30:0]} * {31'b0, b[30:0]};
    m = p[61:15];
    if (m[46:31] != 16'h0) return {1'b1, a[31] ^ b[31], 31'h7FFFFFFF};
    return {1'b0, a[31] ^ b[31], m[30:0]};
  endfunction

  always_comb {mul_ovr, mul_result}   = mul_model(mul_a, mul_b);
  always_comb {mul_ovr4, mul_result4} = mul_model(mul_a4, mul_b4);

  typedef struct {
    logic [1:0]  id;
    logic [31:0] res;
    logic        ovr;
    logic [15:0] cnt;
  } rsp_t;

  rsp_t rsp_q[$];
  int   grant_q[$];
  int   acc_cyc_q[$];
  int   n_vec = 0, n_miss = 0, acc_cnt = 0, last_hs = -100;
  bit   follow_chk = 0, first_acc = 0, valid_prev = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops grant and response expectations whenever the DUT presents them.
  int   mon_g;
  rsp_t mon_e;
  always @(negedge i_clk) begin
    if (!rst_n) begin
      valid_prev = 0;
      acc_cyc_q.delete();
    end else begin
      if (req_ready != 4'b0) begin
        if (grant_q.size() == 0) begin
          check("unexpected_grant", 32'(req_ready), 32'h0);
        end else begin
          mon_g = grant_q.pop_front();
          check("grant_onehot", 32'(req_ready), 32'(1) << mon_g);
          $display("grant: requester %0d at cycle %0d", mon_g, cyc);
        end
        if (follow_chk && !first_acc) check("accept_after_handshake", 32'(cyc - last_hs), 32'd1);
        first_acc = 0;
        acc_cyc_q.push_back(cyc);
        acc_cnt++;
      end
      if (rsp_valid) begin
        check("no_ready_in_resp", 32'(req_ready), 32'h0);
        if (!valid_prev && acc_cyc_q.size() != 0)
          check("latency", 32'(cyc - acc_cyc_q.pop_front()), 32'd2);
        if (rsp_q.size() == 0) begin
          timeout("unexpected_response");
        end else begin
          mon_e = rsp_q[0];
          check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
          check("rsp_result", rsp_result, mon_e.res);
          check("rsp_ovr", 32'(rsp_ovr), 32'(mon_e.ovr));
          check("ovr_count", 32'(ovr_count), 32'(mon_e.cnt));
          if (rsp_ready) begin
            void'(rsp_q.pop_front());
            last_hs = cyc;
            $display("response: id %0d result %h ovr %0d count %h", rsp_id, rsp_result, rsp_ovr, ovr_count);
          end
        end
      end
      valid_prev = rsp_valid;
    end
  end

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b, input logic v);
    req_a[k*32 +: 32] = a;
    req_b[k*32 +: 32] = b;
    req_valid[k]      = v;
  endtask

  task automatic expect_rsp(input int id, input logic [31:0] res, input logic ovr, input logic [15:0] cnt);
    rsp_t e;
    e.id  = 2'(id);
    e.res = res;
    e.ovr = ovr;
    e.cnt = cnt;
    grant_q.push_back(id);
    rsp_q.push_back(e);
  endtask

  task automatic wait_acc(input int target);
    int t = 0;
    while (acc_cnt < target && t < 100) begin
      @(posedge i_clk); #1;
      t++;
    end
    if (acc_cnt < target) timeout("accept");
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((rsp_q.size() != 0 || rsp_valid) && t < 200) begin
      @(posedge i_clk); #1;
      t++;
    end
    if (rsp_q.size() != 0 || rsp_valid) timeout("drain");
  endtask

  task automatic check_reset_main();
    check("rst_mul_a", mul_a, 32'h0);
    check("rst_mul_b", mul_b, 32'h0);
    check("rst_rsp_result", rsp_result, 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_rsp_ovr", 32'(rsp_ovr), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_ovr_count", 32'(ovr_count), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int a0;
    rst_n = 1'b0; rst4_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    req_valid4 = '0; req_a4 = '0; req_b4 = '0; rsp_ready4 = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    set_req(1, 32'h00010000, 32'h00010000, 1'b1);
    #1;
    check_reset_main();
    set_req(1, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1; rst4_n = 1'b1;

    // 1.5 * 2.0 from requester 0
    expect_rsp(0, 32'h00018000, 1'b0, 16'h0000);
    set_req(0, 32'h0000C000, 32'h00010000, 1'b1);
    wait_acc(1);
    set_req(0, 32'h0, 32'h0, 1'b0);
    wait_drain();

    // -1.0 * 2.0 from requester 2
    expect_rsp(2, 32'h80010000, 1'b0, 16'h0000);
    set_req(2, 32'h80008000, 32'h00010000, 1'b1);
    wait_acc(2);
    set_req(2, 32'h0, 32'h0, 1'b0);
    wait_drain();

    // Reset returns the pointer to 0, so all-valid grants run 0,1,2,3,0
    @(posedge i_clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_main();
    @(posedge i_clk); #1;
    rst_n = 1'b1;
    follow_chk = 1; first_acc = 1;
    for (int k = 0; k < 4; k++) begin
      set_req(k, 32'(k + 1) << 15, 32'h00010000, 1'b1);
    end
    expect_rsp(0, 32'h00010000, 1'b0, 16'h0000);
    expect_rsp(1, 32'h00020000, 1'b0, 16'h0000);
    expect_rsp(2, 32'h00030000, 1'b0, 16'h0000);
    expect_rsp(3, 32'h00040000, 1'b0, 16'h0000);
    expect_rsp(0, 32'h00010000, 1'b0, 16'h0000);
    wait_acc(acc_cnt + 5);
    req_valid = '0;
    wait_drain();

    // Backpressure: requester 3 must wait until the held response is taken
    first_acc = 1;
    rsp_ready = 1'b0;
    expect_rsp(1, 32'h0000C000, 1'b0, 16'h0000);
    expect_rsp(3, 32'h80002000, 1'b0, 16'h0000);
    set_req(1, 32'h00008000, 32'h0000C000, 1'b1);
    set_req(3, 32'h00004000, 32'h80004000, 1'b1);
    a0 = acc_cnt;
    wait_acc(a0 + 1);
    set_req(1, 32'h0, 32'h0, 1'b0);
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(posedge i_clk); #1;
      t++;
    end
    if (!rsp_valid) timeout("bp_valid");
    repeat (5) @(posedge i_clk);
    #1;
    rsp_ready = 1'b1;
    wait_acc(a0 + 2);
    set_req(3, 32'h0, 32'h0, 1'b0);
    wait_drain();
    follow_chk = 0;

    // Overflow, then saturation of the counter from 0xFFFE
    expect_rsp(0, 32'h7FFFFFFF, 1'b1, 16'h0001);
    set_req(0, 32'h40000000, 32'h00010000, 1'b1);
    wait_acc(acc_cnt + 1);
    set_req(0, 32'h0, 32'h0, 1'b0);
    wait_drain();

    force dut.ovr_count_reg = 16'hFFFE;
    @(posedge i_clk); #1;
    release dut.ovr_count_reg;
    @(posedge i_clk); #1;
    check("ovr_count_preload", 32'(ovr_count), 32'h0000FFFE);
    expect_rsp(1, 32'hFFFFFFFF, 1'b1, 16'hFFFF);
    set_req(1, 32'hC0000000, 32'h00010000, 1'b1);
    wait_acc(acc_cnt + 1);
    set_req(1, 32'h0, 32'h0, 1'b0);
    wait_drain();
    expect_rsp(2, 32'h7FFFFFFF, 1'b1, 16'hFFFF);
    set_req(2, 32'h40000000, 32'h00010000, 1'b1);
    wait_acc(acc_cnt + 1);
    set_req(2, 32'h0, 32'h0, 1'b0);
    wait_drain();
    check("grant_q_empty", 32'(grant_q.size()), 32'h0);
    check("rsp_q_empty", 32'(rsp_q.size()), 32'h0);

    // MUL_LAT=4: reset during WAIT discards the operation and the pointer
    req_a4[2*32 +: 32] = 32'h00008000;
    req_b4[2*32 +: 32] = 32'h00008000;
    req_valid4[2] = 1'b1;
    t = 0;
    do begin
      @(negedge i_clk);
      t++;
    end while (!req_ready4[2] && t < 20);
    if (!req_ready4[2]) timeout("lat4_first_accept");
    @(posedge i_clk); #1;
    req_valid4[2] = 1'b0;
    @(posedge i_clk); #1;
    check("lat4_busy_in_wait", 32'(busy4), 32'h1);
    #2;
    rst4_n = 1'b0;
    req_a4[1*32 +: 32] = 32'h00008000;
    req_b4[1*32 +: 32] = 32'h00030000;
    req_a4[3*32 +: 32] = 32'h00010000;
    req_b4[3*32 +: 32] = 32'h00010000;
    req_valid4 = 4'b1010;
    #1;
    check("lat4_rst_mul_a", mul_a4, 32'h0);
    check("lat4_rst_mul_b", mul_b4, 32'h0);
    check("lat4_rst_busy", 32'(busy4), 32'h0);
    check("lat4_rst_valid", 32'(rsp_valid4), 32'h0);
    check("lat4_rst_ready", 32'(req_ready4), 32'h0);
    check("lat4_rst_result", rsp_result4, 32'h0);
    check("lat4_rst_id", 32'(rsp_id4), 32'h0);
    check("lat4_rst_ovr", 32'(rsp_ovr4), 32'h0);
    check("lat4_rst_count", 32'(ovr_count4), 32'h0);
    @(posedge i_clk); #1;
    rst4_n = 1'b1;
    t = 0;
    do begin
      @(negedge i_clk);
      t++;
    end while (req_ready4 == 4'b0 && !rsp_valid4 && t < 5);
    check("lat4_grant_after_reset", 32'(req_ready4), 32'h2);
    a0 = cyc;
    @(posedge i_clk); #1;
    req_valid4 = '0;
    t = 0;
    do begin
      @(negedge i_clk);
      t++;
    end while (!rsp_valid4 && t < 20);
    if (!rsp_valid4) timeout("lat4_response");
    check("lat4_latency", 32'(cyc - a0), 32'd5);
    check("lat4_rsp_id", 32'(rsp_id4), 32'h1);
    check("lat4_rsp_result", rsp_result4, 32'h00030000);
    check("lat4_rsp_ovr", 32'(rsp_ovr4), 32'h0);
    $display("response4: id %0d result %h at cycle %0d", rsp_id4, rsp_result4, cyc);
    repeat (3) @(posedge i_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
